// File: rtl/mul_radix2_host.sv
// Host-side master for the nibble-serial radix-2 multiplier.
// Takes a parallel operand pair, streams A then B LSB-nibble-first behind a
// one-cycle start pulse, and rebuilds the serial result into a parallel word.
// Timeouts and wrong result-nibble counts are reported on res_error.
module mul_radix2_host #(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [BIT_WIDTH-1:0] op_a,
  input  logic [BIT_WIDTH-1:0] op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BIT_WIDTH-1:0] res_data,
  output logic                 res_error,
  output logic                 mul_start,
  output logic [3:0]           mul_data_in,
  input  logic [3:0]           mul_data_out,
  input  logic                 mul_data_out_valid,
  input  logic                 mul_result_complete,
  input  logic                 mul_ready
);

  localparam int unsigned N   = BIT_WIDTH / 4;
  localparam int unsigned TXW = $clog2(2 * N) + 1;
  localparam int unsigned RXW = $clog2(N + 1) + 1;
  localparam int unsigned TMW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  localparam logic [TXW-1:0] TX_LAST = TXW'(2 * N - 1);
  localparam logic [RXW-1:0] RX_FULL = RXW'(N);
  localparam logic [RXW-1:0] RX_LAST = RXW'(N - 1);
  localparam logic [TMW-1:0] TM_LAST = TMW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_SEND,
    S_COLLECT,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [2*BIT_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [TXW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BIT_WIDTH-1:0]   rx_sr_q, rx_sr_d;
  logic [RXW-1:0]         rx_cnt_q, rx_cnt_d;
  logic                   rx_ovf_q, rx_ovf_d;
  logic [TMW-1:0]         timer_q, timer_d;
  logic                   err_q, err_d;
  logic                   start_q, start_d;
  logic [3:0]             din_q, din_d;

  // Registered outputs; res_valid/op_ready decode only the state flop.
  assign op_ready    = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_RESP);
  assign res_data    = rx_sr_q;
  assign res_error   = err_q;
  assign mul_start   = start_q;
  assign mul_data_in = din_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
      rx_sr_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      tx_cnt_q <= tx_cnt_d;
      rx_sr_q  <= rx_sr_d;
      rx_cnt_q <= rx_cnt_d;
      rx_ovf_q <= rx_ovf_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      start_q  <= start_d;
      din_q    <= din_d;
    end
  end

  // Next-state, nibble transmit, result capture and timeout logic.
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    rx_sr_d  = rx_sr_q;
    rx_cnt_d = rx_cnt_q;
    rx_ovf_d = rx_ovf_q;
    timer_d  = timer_q;
    err_d    = err_q;
    start_d  = 1'b0;
    din_d    = '0;

    // Result nibbles can overlap the tail of SEND, so capture runs in both
    // states; nibbles beyond N are dropped and only flagged.
    if ((state_q == S_SEND || state_q == S_COLLECT) && mul_data_out_valid) begin
      if (rx_cnt_q < RX_FULL) begin
        rx_sr_d  = {mul_data_out, rx_sr_q[BIT_WIDTH-1:4]};
        rx_cnt_d = rx_cnt_q + 1'b1;
      end else begin
        rx_ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          tx_sr_d  = {op_b, op_a};
          tx_cnt_d = '0;
          rx_sr_d  = '0;
          rx_cnt_d = '0;
          rx_ovf_d = 1'b0;
          timer_d  = '0;
          err_d    = 1'b0;
          state_d  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        // The first SEND nibble is loaded here so it leaves a flop together
        // with the start pulse.
        if (mul_ready) begin
          start_d  = 1'b1;
          din_d    = tx_sr_q[3:0];
          tx_sr_d  = {4'h0, tx_sr_q[2*BIT_WIDTH-1:4]};
          tx_cnt_d = '0;
          timer_d  = '0;
          state_d  = S_SEND;
        end else if (timer_q == TM_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SEND: begin
        if (tx_cnt_q == TX_LAST) begin
          timer_d = '0;
          state_d = S_COLLECT;
        end else begin
          din_d    = tx_sr_q[3:0];
          tx_sr_d  = {4'h0, tx_sr_q[2*BIT_WIDTH-1:4]};
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_COLLECT: begin
        // The completing nibble is the N-th only if exactly N-1 came before.
        if (mul_data_out_valid && mul_result_complete) begin
          err_d   = (rx_cnt_q != RX_LAST) || rx_ovf_q;
          state_d = S_RESP;
        end else if (timer_q == TM_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_radix2_host.sv
// Bench for mul_radix2_host: behavioural multiplier stub, expectation-queue
// model checked every cycle, and directed operations with literal results.
module tb_mul_radix2_host;

  localparam int unsigned BW = 32;
  localparam int unsigned TO = 64;
  localparam int N = BW / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [BW-1:0] op_a = '0;
  logic [BW-1:0] op_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [BW-1:0] res_data;
  logic          res_error;
  logic          mul_start;
  logic [3:0]    mul_data_in;
  logic [3:0]    m_dout;
  logic          m_valid, m_complete, stub_ready, mul_ready_w;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Stub controls
  int stub_mode = 0;    // 0 normal, 1 never complete, 2 seven nibbles then complete
  int ready_extra = 0;  // extra cycles before ready returns
  bit force_nr = 1'b0;  // hold mul_ready low

  assign mul_ready_w = stub_ready && !force_nr;

  mul_radix2_host #(.BIT_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .mul_start(mul_start), .mul_data_in(mul_data_in),
    .mul_data_out(m_dout), .mul_data_out_valid(m_valid),
    .mul_result_complete(m_complete), .mul_ready(mul_ready_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- multiplier stub ----------------
  bit          s_busy = 1'b0;
  int          s_j, s_cj, s_k;
  logic [31:0] s_a, s_b;
  logic [63:0] s_p;

  always @(posedge clk) begin
    if (!rst_n) begin
      s_busy = 1'b0; s_j = 0; s_a = '0; s_b = '0;
      stub_ready <= 1'b1; m_valid <= 1'b0; m_complete <= 1'b0; m_dout <= '0;
    end else begin
      m_valid <= 1'b0; m_complete <= 1'b0; m_dout <= '0;
      if (mul_start) chk("start_while_mul_busy", 64'(s_busy), 64'd0);
      if (!s_busy && mul_start) begin
        s_busy = 1'b1; s_j = 1; s_a = {28'h0, mul_data_in}; s_b = '0;
        stub_ready <= 1'b0;
      end else if (s_busy) begin
        s_j++;
        if (s_j - 1 < N) s_a = s_a | (32'(mul_data_in) << (4 * (s_j - 1)));
        else if (s_j - 1 < 2 * N) s_b = s_b | (32'(mul_data_in) << (4 * (s_j - 1 - N)));
        s_cj = (stub_mode == 2) ? N + 8 : 2 * N + 1;
        s_k  = s_j - (N + 2);
        if (s_k >= 0 && s_j <= s_cj) begin
          s_p = 64'(s_a) * 64'(s_b);
          m_valid    <= 1'b1;
          m_dout     <= s_p[4*s_k +: 4];
          m_complete <= (s_j == s_cj) && (stub_mode != 1);
        end
        if (s_j == s_cj + 2 + ready_extra) begin
          s_busy = 1'b0;
          stub_ready <= 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a, b, data;
    bit          chk_data;
    bit          err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  bit   in_reset = 1'b1;

  always @(posedge clk) begin
    exp_t e;
    logic [63:0] p;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      if (op_valid && op_ready) begin
        p = 64'(op_a) * 64'(op_b);
        e.a = op_a; e.b = op_b;
        if (force_nr) begin
          e.data = '0; e.chk_data = 1'b1; e.err = 1'b1; e.lat = -1;
        end else if (stub_mode == 1) begin
          e.data = '0; e.chk_data = 1'b0; e.err = 1'b1; e.lat = 2 * N + TO;
        end else if (stub_mode == 2) begin
          e.data = '0; e.chk_data = 1'b0; e.err = 1'b1; e.lat = N + 9;
        end else begin
          e.data = p[31:0]; e.chk_data = 1'b1; e.err = 1'b0; e.lat = 2 * N + 2;
        end
        exp_q.push_back(e);
      end
      if (res_valid && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          sending = 1'b0;
  int          idx = 0;
  int          start_cyc = 0;
  bit          rv_prev = 1'b0;
  logic [63:0] src;

  always @(negedge clk) begin
    if (in_reset) begin
      chk("rst_op_ready", 64'(op_ready), 64'd1);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_error", 64'(res_error), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_mul_start", 64'(mul_start), 64'd0);
      chk("rst_mul_data_in", 64'(mul_data_in), 64'd0);
      sending = 1'b0;
      rv_prev = 1'b0;
    end else begin
      if (sending) begin
        chk("start_single_cycle", 64'(mul_start), 64'd0);
        chk("stream_nibble", 64'(mul_data_in), 64'(src[4*idx +: 4]));
        idx++;
        if (idx == 2 * N) sending = 1'b0;
      end else if (mul_start) begin
        if (exp_q.size() == 0) begin
          chk("start_without_op", 64'd1, 64'd0);
        end else begin
          src = {exp_q[0].b, exp_q[0].a};
          chk("stream_nibble0", 64'(mul_data_in), 64'(src[3:0]));
        end
        idx = 1;
        sending = 1'b1;
        start_cyc = cyc;
      end else begin
        chk("idle_data_in", 64'(mul_data_in), 64'd0);
      end
      if (res_valid) begin
        chk("op_ready_low_in_resp", 64'(op_ready), 64'd0);
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 64'd1, 64'd0);
        end else begin
          chk("model_res_error", 64'(res_error), 64'(exp_q[0].err));
          if (exp_q[0].chk_data) chk("model_res_data", 64'(res_data), 64'(exp_q[0].data));
          if (!rv_prev && exp_q[0].lat >= 0)
            chk("res_latency", 64'(cyc - start_cyc), 64'(exp_q[0].lat));
        end
      end
      rv_prev = res_valid;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic offer(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    op_a = a; op_b = b; op_valid = 1'b1;
    while (!op_ready && n < 400) begin tick(); n++; end
    if (n >= 400) chk("offer_timeout", 64'd1, 64'd0);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       input logic [31:0] lit_data, input bit chk_data, input bit lit_err,
                       input int exp_starts, input int lit_din);
    int n = 0;
    int starts = 0;
    logic [3:0] first_din = '0;
    offer(a, b);
    while (!res_valid && n < 400) begin
      if (mul_start) begin
        if (starts == 0) first_din = mul_data_in;
        starts++;
      end
      tick();
      n++;
    end
    chk("res_valid_arrives", 64'(res_valid), 64'd1);
    chk("start_pulses", 64'(starts), 64'(exp_starts));
    if (lit_din >= 0) chk("first_data_in", 64'(first_din), 64'(lit_din));
    for (int i = 0; i <= hold; i++) begin
      chk("lit_res_valid_held", 64'(res_valid), 64'd1);
      chk("lit_op_ready_low", 64'(op_ready), 64'd0);
      chk("lit_res_error", 64'(res_error), 64'(lit_err));
      if (chk_data) chk("lit_res_data", 64'(res_data), 64'(lit_data));
      if (i < hold) tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_dropped", 64'(res_valid), 64'd0);
    chk("op_ready_back", 64'(op_ready), 64'd1);
  endtask

  logic [31:0] got_v[2];
  int          got_n;

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_op_ready", 64'(op_ready), 64'd1);
    chk("reset_mul_start", 64'(mul_start), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op(32'd3, 32'd5, 10, 32'h0000000F, 1'b1, 1'b0, 1, 3);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 1'b1, 1'b0, 1, -1);
    do_op(32'h12345678, 32'h10, 2, 32'h23456780, 1'b1, 1'b0, 1, -1);

    stub_mode = 1;
    do_op(32'd11, 32'd13, 1, 32'h0, 1'b0, 1'b1, 1, -1);
    repeat (4) tick();
    stub_mode = 2;
    do_op(32'h01020304, 32'h00000507, 1, 32'h0, 1'b0, 1'b1, 1, -1);
    repeat (4) tick();
    stub_mode = 0;

    force_nr = 1'b1;
    do_op(32'd5, 32'd5, 1, 32'h0, 1'b1, 1'b1, 0, -1);
    force_nr = 1'b0;

    // Reset asserted during SEND cycle 5
    offer(32'h11111111, 32'h22222222);
    n = 0;
    while (!mul_start && n < 200) begin tick(); n++; end
    chk("reset_test_start_seen", 64'(mul_start), 64'd1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_mul_start", 64'(mul_start), 64'd0);
    chk("midrst_mul_data_in", 64'(mul_data_in), 64'd0);
    chk("midrst_op_ready", 64'(op_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    do_op(32'd7, 32'd6, 0, 32'd42, 1'b1, 1'b0, 1, 7);

    // Back-to-back with res_ready tied high and a slow mul_ready return
    res_ready = 1'b1;
    ready_extra = 4;
    got_n = 0;
    fork
      begin
        offer(32'd9, 32'd9);
        offer(32'h00010000, 32'h00010000);
      end
      begin
        for (int k = 0; k < 600 && got_n < 2; k++) begin
          if (res_valid) begin
            got_v[got_n] = res_data;
            got_n++;
          end
          tick();
        end
      end
    join
    chk("b2b_count", 64'(got_n), 64'd2);
    chk("b2b_first", 64'(got_v[0]), 64'd81);
    chk("b2b_second", 64'(got_v[1]), 64'd0);
    res_ready = 1'b0;
    ready_extra = 0;
    repeat (5) tick();
    chk("model_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
